// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two requesters onto one shared synchronous memory.
// The read and write ports are arbitrated independently, so one read and one
// write can be granted in the same cycle. Each port uses a 1-bit round-robin
// pointer. Read data returns one cycle after the grant and is tagged with the
// index of the requester that was granted.
//
// Optional feature (macro MEM_ARBITER_RAW_BYPASS_EN): when a read and a write
// are granted in the same cycle to the same address, the written data is
// returned on rd_data on the following cycle.
//
// Ports:
//   clock, rst_n            clock, asynchronous active-low reset
//   rd_req/rd_addr          per-requester read requests and addresses
//   rd_gnt                  one-hot-or-zero read grant (combinational)
//   rd_valid/rd_data        tagged read return, one cycle after the grant
//   wr_req/wr_addr/wr_data  per-requester write requests, addresses and data
//   wr_gnt                  one-hot-or-zero write grant (combinational)
//   mem_rden/mem_rdaddress  memory read control
//   mem_wren/mem_wraddress/mem_data  memory write control
//   mem_q                   memory read data, valid one cycle after mem_rden
module mem_arbiter #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [1:0]         rd_req,
    input  logic [2*AW-1:0]    rd_addr,
    output logic [1:0]         rd_gnt,
    output logic [1:0]         rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    input  logic [1:0]         wr_req,
    input  logic [2*AW-1:0]    wr_addr,
    input  logic [2*WIDTH-1:0] wr_data,
    output logic [1:0]         wr_gnt,
    output logic               mem_rden,
    output logic [AW-1:0]      mem_rdaddress,
    output logic               mem_wren,
    output logic [AW-1:0]      mem_wraddress,
    output logic [WIDTH-1:0]   mem_data,
    input  logic [WIDTH-1:0]   mem_q
);

    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic             r_rd_vld;
    logic             r_tag;
    logic [1:0]       w_rd_gnt;
    logic [1:0]       w_wr_gnt;
    logic [WIDTH-1:0] w_rd_src;

    // Both requesting: the pointer picks the winner; otherwise the sole
    // requester (or nobody) wins.
    function automatic logic [1:0] arb(input logic [1:0] req, input logic ptr);
        if (req == 2'b11)
            return ptr ? 2'b10 : 2'b01;
        return req;
    endfunction

    // Grants are forced to zero while reset is asserted.
    always_comb begin
        w_rd_gnt = 2'b00;
        w_wr_gnt = 2'b00;
        if (rst_n) begin
            w_rd_gnt = arb(rd_req, r_rd_ptr);
            w_wr_gnt = arb(wr_req, r_wr_ptr);
        end
    end

    assign rd_gnt = w_rd_gnt;
    assign wr_gnt = w_wr_gnt;

    always_comb begin
        mem_rden      = |w_rd_gnt;
        mem_rdaddress = '0;
        if (w_rd_gnt[1])
            mem_rdaddress = rd_addr[AW +: AW];
        else if (w_rd_gnt[0])
            mem_rdaddress = rd_addr[0 +: AW];

        mem_wren      = |w_wr_gnt;
        mem_wraddress = '0;
        mem_data      = '0;
        if (w_wr_gnt[1]) begin
            mem_wraddress = wr_addr[AW +: AW];
            mem_data      = wr_data[WIDTH +: WIDTH];
        end else if (w_wr_gnt[0]) begin
            mem_wraddress = wr_addr[0 +: AW];
            mem_data      = wr_data[0 +: WIDTH];
        end
    end

    // After a grant the pointer prefers the requester that was not granted.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (|w_rd_gnt) r_rd_ptr <= w_rd_gnt[0];
            if (|w_wr_gnt) r_wr_ptr <= w_wr_gnt[0];
        end
    end

    // Read return tracking: one valid flag plus the grantee index.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0;
            r_tag    <= 1'b0;
        end else begin
            r_rd_vld <= |w_rd_gnt;
            if (|w_rd_gnt) r_tag <= w_rd_gnt[1];
        end
    end

    assign rd_valid = r_rd_vld ? (r_tag ? 2'b10 : 2'b01) : 2'b00;

`ifdef MEM_ARBITER_RAW_BYPASS_EN
    // The memory returns old contents on a same-cycle read/write collision;
    // capture the write data so the read sees the new value.
    logic             r_byp_vld;
    logic [WIDTH-1:0] r_byp_data;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_vld  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_vld  <= mem_rden && mem_wren && (mem_rdaddress == mem_wraddress);
            r_byp_data <= mem_data;
        end
    end

    assign w_rd_src = r_byp_vld ? r_byp_data : mem_q;
`else
    assign w_rd_src = mem_q;
`endif

    assign rd_data = r_rd_vld ? w_rd_src : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory
// (read-before-write, one cycle read latency) attached to the memory port.
module tb_mem_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic               clock = 1'b0;
    logic               rst_n;
    logic [1:0]         rd_req;
    logic [2*AW-1:0]    rd_addr;
    logic [1:0]         rd_gnt;
    logic [1:0]         rd_valid;
    logic [WIDTH-1:0]   rd_data;
    logic [1:0]         wr_req;
    logic [2*AW-1:0]    wr_addr;
    logic [2*WIDTH-1:0] wr_data;
    logic [1:0]         wr_gnt;
    logic               mem_rden;
    logic [AW-1:0]      mem_rdaddress;
    logic               mem_wren;
    logic [AW-1:0]      mem_wraddress;
    logic [WIDTH-1:0]   mem_data;
    logic [WIDTH-1:0]   mem_q = '0;

    logic [WIDTH-1:0]   mem [DEPTH];

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_rden(mem_rden), .mem_rdaddress(mem_rdaddress),
        .mem_wren(mem_wren), .mem_wraddress(mem_wraddress),
        .mem_data(mem_data), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rden) mem_q <= mem[mem_rdaddress];
        if (mem_wren) mem[mem_wraddress] <= mem_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    logic [1:0] exp_g [4];
    logic [WIDTH-1:0] exp_raw;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h40 + i);
        mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = 8'hA5; mem[7] = 8'h00;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`ifdef MEM_ARBITER_RAW_BYPASS_EN
        exp_raw = 8'h5A;
`else
        exp_raw = 8'h00;
`endif

        // Reset with requests pending: everything must stay quiet.
        rst_n = 1'b0; rd_req = 2'b11; wr_req = 2'b11;
        rd_addr = {6'd2, 6'd1}; wr_addr = {6'd4, 6'd3}; wr_data = 16'h0000;
        #2;
        chk("rst_rd_gnt", 32'(rd_gnt), 0);
        chk("rst_wr_gnt", 32'(wr_gnt), 0);
        chk("rst_mem_rden", 32'(mem_rden), 0);
        chk("rst_mem_wren", 32'(mem_wren), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        next(); next();
        chk("rst_rd_valid_clk", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);

        // Both reading for 4 cycles; first grant in the first cycle out of reset.
        rst_n = 1'b1; wr_req = 2'b00;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_gnt", 32'(rd_gnt), 32'(exp_g[k]));
            chk("rr_addr", 32'(mem_rdaddress), (exp_g[k] == 2'b01) ? 1 : 2);
            if (k > 0) begin
                chk("rr_valid", 32'(rd_valid), 32'(exp_g[k-1]));
                chk("rr_data", 32'(rd_data), (exp_g[k-1] == 2'b01) ? 32'h41 : 32'h42);
            end
            next();
        end
        rd_req = 2'b00;
        #1;
        chk("rr_valid_last", 32'(rd_valid), 2'b10);
        chk("rr_data_last", 32'(rd_data), 32'h42);
        chk("idle_rd_gnt", 32'(rd_gnt), 0);
        chk("idle_rden", 32'(mem_rden), 0);
        chk("idle_rdaddr", 32'(mem_rdaddress), 0);
        next();
        chk("idle_valid", 32'(rd_valid), 0);
        chk("idle_data_zero", 32'(rd_data), 0);

        // Sole requester 1 reading address 5.
        rd_req = 2'b10; rd_addr = {6'd5, 6'd0};
        #1;
        chk("sole_gnt", 32'(rd_gnt), 2'b10);
        chk("sole_rden", 32'(mem_rden), 1);
        chk("sole_addr", 32'(mem_rdaddress), 5);
        next();
        rd_req = 2'b00;
        #1;
        chk("sole_valid", 32'(rd_valid), 2'b10);
        chk("sole_data", 32'(rd_data), 32'hA5);

        // Both writing for 2 cycles.
        wr_req = 2'b11; wr_addr = {6'd4, 6'd3}; wr_data = {8'h22, 8'h11};
        #1;
        chk("wr_gnt0", 32'(wr_gnt), 2'b01);
        chk("wr_wren0", 32'(mem_wren), 1);
        chk("wr_addr0", 32'(mem_wraddress), 3);
        chk("wr_data0", 32'(mem_data), 32'h11);
        next();
        chk("wr_mem3", 32'(mem[3]), 32'h11);
        chk("wr_gnt1", 32'(wr_gnt), 2'b10);
        chk("wr_addr1", 32'(mem_wraddress), 4);
        chk("wr_data1", 32'(mem_data), 32'h22);
        next();
        wr_req = 2'b00;
        #1;
        chk("wr_mem4", 32'(mem[4]), 32'h22);
        chk("wr_idle_gnt", 32'(wr_gnt), 0);
        chk("wr_idle_wren", 32'(mem_wren), 0);
        chk("wr_idle_data", 32'(mem_data), 0);

        // Same-cycle read and write to address 7.
        wr_req = 2'b01; wr_addr = {6'd0, 6'd7}; wr_data = {8'h00, 8'h5A};
        rd_req = 2'b01; rd_addr = {6'd0, 6'd7};
        #1;
        chk("raw_rd_gnt", 32'(rd_gnt), 2'b01);
        chk("raw_wr_gnt", 32'(wr_gnt), 2'b01);
        next();
        rd_req = 2'b00; wr_req = 2'b00;
        #1;
        chk("raw_valid", 32'(rd_valid), 2'b01);
        chk("raw_data", 32'(rd_data), 32'(exp_raw));
        chk("raw_mem7", 32'(mem[7]), 32'h5A);
        next();

        // Reset pulsed while a read is in flight; pointers were both at 1.
        rd_req = 2'b01; rd_addr = {6'd0, 6'd1};
        #1;
        chk("int_gnt", 32'(rd_gnt), 2'b01);
        #2;
        rst_n = 1'b0; rd_req = 2'b11; wr_req = 2'b11; wr_addr = {6'd9, 6'd8};
        #1;
        chk("int_rst_rd_gnt", 32'(rd_gnt), 0);
        chk("int_rst_wr_gnt", 32'(wr_gnt), 0);
        chk("int_rst_rden", 32'(mem_rden), 0);
        chk("int_rst_wren", 32'(mem_wren), 0);
        chk("int_rst_valid", 32'(rd_valid), 0);
        next();
        chk("int_rst_valid_clk", 32'(rd_valid), 0);
        chk("int_rst_data", 32'(rd_data), 0);
        #2;
        rst_n = 1'b1; rd_req = 2'b00; wr_req = 2'b00;
        next();
        chk("int_post_valid", 32'(rd_valid), 0);
        rd_req = 2'b11; rd_addr = {6'd2, 6'd1}; wr_req = 2'b11;
        #1;
        chk("int_post_rd_gnt", 32'(rd_gnt), 2'b01);
        chk("int_post_wr_gnt", 32'(wr_gnt), 2'b01);
        next();
        rd_req = 2'b00; wr_req = 2'b00;
        #1;
        chk("int_post_valid2", 32'(rd_valid), 2'b01);
        chk("int_post_data2", 32'(rd_data), 32'h41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
